// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer between the pc unit and instruction memory
//
// Issues one fetch at a time at the current PC, holds the PC (stay) until the
// fetch is accepted or a redirect occurs, and presents fetched words to decode
// through a one-entry valid/ready output register. Responses that belong to a
// redirected path are discarded; a watchdog flags fetches that never return.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   pc                 current PC from the pc unit
//   redirect           taken branch/jump resolved this cycle
//   halt               stop issuing new fetches
//   imem_req/addr      fetch request toward instruction memory (addr == pc)
//   imem_gnt           request accepted
//   imem_rvalid/rdata  fetch response
//   stay               1 holds the PC in the pc unit
//   if_valid/instr/pc  output register toward decode
//   if_ready           decode accepts the output register
//   fetch_timeout      sticky watchdog error

module fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        stay,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_timeout
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pending_pc_q;
    logic        slot_free;
    logic        accept;
    logic        load;
    logic        timeout_set;

    assign imem_addr = pc;
    assign slot_free = !if_valid || if_ready;
    assign accept    = (state_q == S_REQ) && imem_req && imem_gnt;
    assign stay      = !(accept || redirect);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        imem_req    = 1'b0;
        load        = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A redirect holds the current state so the new PC settles first.
                if (!redirect && !halt) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                imem_req = slot_free && !halt && !redirect;
                if (imem_req && imem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = 16'd0;
                end else if (!redirect && halt) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // A response colliding with a redirect is stale; the pc unit
                    // already holds the target, so fetch again regardless of halt.
                    load    = !redirect;
                    state_d = (redirect || !halt) ? S_REQ : S_IDLE;
                end else if (redirect) begin
                    state_d = S_DROP;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TMO) begin
                        state_d     = S_ERR;
                        timeout_set = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = halt ? S_IDLE : S_REQ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == TMO) begin
                        state_d     = S_ERR;
                        timeout_set = 1'b1;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_pc_q  <= 32'd0;
            if_valid      <= 1'b0;
            if_instr      <= 32'd0;
            if_pc         <= 32'd0;
            fetch_timeout <= 1'b0;
        end else begin
            if (accept) begin
                pending_pc_q <= pc;
            end
            // A load wins over a simultaneous dequeue so no word is lost.
            if (load) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pending_pc_q;
            end else if (redirect && (state_q != S_ERR)) begin
                if_valid <= 1'b0;
            end else if (if_ready) begin
                if_valid <= 1'b0;
            end
            if (timeout_set) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

endmodule
